round_target_gen: RTL and testbench
===================================

// Module: round_target_gen
// PURPOSE
//  Produces the 4-bit target number that the player must reproduce on the switches,
//  and runs the round sequence around it. target drives the comparator's num_1 input;
//  the comparator's match output comes back here and is sampled on the player's submit.
//  Each round has a per-round time limit. The block counts hits and ends the game after
//  MAX_ROUNDS rounds.
// PARAMETERS
//  TIMEOUT_CYCLES  50_000_000  clock cycles allowed per round (1 s at 50 MHz); range 1..2^32-1
//  MAX_ROUNDS      10          rounds per game; range 1..15
//  LFSR_SEED       8'hA5       LFSR reset value; must be nonzero
// PORTS
//  clk          in   1  system clock; all logic is on the rising edge
//  rst          in   1  synchronous, active-high reset
//  start        in   1  single-cycle pulse; starts a new game
//  submit       in   1  single-cycle pulse; the player confirms the switch value
//  match        in   1  comparator result (target == switches); combinational
//  target       out  4  current target number, routed to the comparator and the display
//  target_valid out  1  high while a round is open and waiting for submit
//  round_no     out  4  current round number, 1..MAX_ROUNDS; 0 when idle
//  score        out  4  hits so far in this game
//  result_ok    out  1  one-cycle pulse: the round ended in a hit
//  result_miss  out  1  one-cycle pulse: the round ended in a wrong submit or a timeout
//  game_over    out  1  held high from the end of the last round until the next start
// BEHAVIOUR
//  - Reset values: every output is 0; the FSM is in IDLE; the LFSR holds LFSR_SEED;
//    prev_target is 0; the timer is 0.
//  - LFSR: 8 bits, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle outside reset,
//    so the player's start timing supplies the entropy.
//  - FSM states:
//    IDLE:   start -> GEN. In the same cycle, clear score and round_no.
//    GEN:    if lfsr[3:0] != prev_target, or this is round 1:
//              load target and prev_target with lfsr[3:0], set target_valid,
//              increment round_no, load the timer with TIMEOUT_CYCLES, -> SHOW.
//            Otherwise stay in GEN. The LFSR keeps stepping, so the state exits within
//            a few cycles.
//    SHOW:   The timer decrements once per cycle.
//              submit & match  -> set hit, score+1 (saturates at 15), -> RESULT.
//              submit & !match -> set miss, -> RESULT.
//              timer == 1 and no submit -> set miss, -> RESULT.
//            If submit arrives in the same cycle as the expiry, submit wins.
//    RESULT: Pulse result_ok or result_miss for exactly one cycle; clear target_valid.
//            target keeps its value.
//              round_no == MAX_ROUNDS -> DONE.
//              otherwise              -> GEN.
//    DONE:   game_over = 1. score, round_no and target hold. start -> GEN; clear score,
//            clear round_no, clear game_over.
//  - Ignored inputs: start is ignored in GEN, SHOW and RESULT. submit is ignored outside SHOW.
//  - Timing: target_valid rises on the edge that leaves GEN. match is sampled on the same
//    edge that samples submit. result_* rises one edge after submit or expiry.
//  - Round length: at most TIMEOUT_CYCLES cycles in SHOW.
//  - rst mid-game: return to the reset state on the next edge; no result pulse is issued.
//  - result_ok and result_miss are never high together.
// TESTING  (TIMEOUT_CYCLES=8, MAX_ROUNDS=3)
//  1. Reset and idle: hold rst 2 cycles, idle 5 cycles -> all outputs 0; start pulse ->
//     target_valid=1 within 2-8 cycles, round_no=1.
//  2. Hit: in SHOW, match=1, submit pulse -> result_ok for 1 cycle, score=1,
//     target_valid=0, next round_no=2.
//  3. Timeout: no submit for 8 SHOW cycles -> result_miss on the expiry edge, score unchanged.
//     Also drive submit & match on the final cycle -> result_ok instead.
//  4. Full game: hit, miss, hit -> game_over=1, score=2, round_no=3; no further pulses.
//     start -> score=0, round_no=1.
//  5. No repeat: over 200 rounds with varied start timing, target != previous target every
//     round; no lockup in GEN.
//  6. Reset mid-SHOW: assert rst -> next edge all outputs 0, no result pulse. start pulse
//     while in SHOW -> ignored.

Source files
------------

// File: rtl/round_target_gen.sv
// Round sequencer for the reaction game: picks a non-repeating 4-bit target from an
// LFSR, times each round, scores hits and ends the game after MAX_ROUNDS rounds.
module round_target_gen #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_ROUNDS     = 10,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_submit,
  input  logic       i_match,
  output logic [3:0] o_target,
  output logic       o_target_valid,
  output logic [3:0] o_round_no,
  output logic [3:0] o_score,
  output logic       o_result_ok,
  output logic       o_result_miss,
  output logic       o_game_over
);

  // state    | meaning
  // S_IDLE   | waiting for the first start after reset
  // S_GEN    | drawing a target that differs from the previous one
  // S_SHOW   | round open, timer running, waiting for submit
  // S_RESULT | one-cycle hit/miss pulse
  // S_DONE   | game over, waiting for start
  typedef enum logic [2:0] {S_IDLE, S_GEN, S_SHOW, S_RESULT, S_DONE} state_t;

  localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);
  localparam logic [3:0]  LP_MAX     = 4'(MAX_ROUNDS);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_lfsr;
  logic [7:0]  w_lfsr_nxt;
  logic [3:0]  r_prev, w_prev_nxt;
  logic [31:0] r_timer, w_timer_nxt;
  logic [3:0]  r_target, w_target_nxt;
  logic        r_valid, w_valid_nxt;
  logic [3:0]  r_round, w_round_nxt;
  logic [3:0]  r_score, w_score_nxt;
  logic        r_ok, w_ok_nxt;
  logic        r_miss, w_miss_nxt;
  logic        r_over, w_over_nxt;

  // x^8+x^6+x^5+x^4+1, free-running so start timing picks the sequence position
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= LFSR_SEED;
      r_prev   <= 4'd0;
      r_timer  <= 32'd0;
      r_target <= 4'd0;
      r_valid  <= 1'b0;
      r_round  <= 4'd0;
      r_score  <= 4'd0;
      r_ok     <= 1'b0;
      r_miss   <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_prev   <= w_prev_nxt;
      r_timer  <= w_timer_nxt;
      r_target <= w_target_nxt;
      r_valid  <= w_valid_nxt;
      r_round  <= w_round_nxt;
      r_score  <= w_score_nxt;
      r_ok     <= w_ok_nxt;
      r_miss   <= w_miss_nxt;
      r_over   <= w_over_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_timer_nxt  = r_timer;
    w_target_nxt = r_target;
    w_valid_nxt  = r_valid;
    w_round_nxt  = r_round;
    w_score_nxt  = r_score;
    w_ok_nxt     = 1'b0;
    w_miss_nxt   = 1'b0;
    w_over_nxt   = r_over;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_GEN;
          w_score_nxt = 4'd0;
          w_round_nxt = 4'd0;
        end
      end
      S_GEN: begin
        // round 1 may repeat the last target of the previous game
        if ((r_lfsr[3:0] != r_prev) || (r_round == 4'd0)) begin
          w_target_nxt = r_lfsr[3:0];
          w_prev_nxt   = r_lfsr[3:0];
          w_valid_nxt  = 1'b1;
          w_round_nxt  = r_round + 4'd1;
          w_timer_nxt  = LP_TIMEOUT;
          w_state_nxt  = S_SHOW;
        end
      end
      S_SHOW: begin
        w_timer_nxt = r_timer - 32'd1;
        if (i_submit) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_RESULT;
          if (i_match) begin
            w_ok_nxt    = 1'b1;
            w_score_nxt = (r_score == 4'd15) ? 4'd15 : r_score + 4'd1;
          end else begin
            w_miss_nxt  = 1'b1;
          end
        end else if (r_timer == 32'd1) begin
          w_valid_nxt = 1'b0;
          w_miss_nxt  = 1'b1;
          w_state_nxt = S_RESULT;
        end
      end
      S_RESULT: begin
        if (r_round == LP_MAX) begin
          w_state_nxt = S_DONE;
          w_over_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_GEN;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_GEN;
          w_score_nxt = 4'd0;
          w_round_nxt = 4'd0;
          w_over_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_target       = r_target;
  assign o_target_valid = r_valid;
  assign o_round_no     = r_round;
  assign o_score        = r_score;
  assign o_result_ok    = r_ok;
  assign o_result_miss  = r_miss;
  assign o_game_over    = r_over;

endmodule

// File: tb/tb_round_target_gen.sv
// Scoreboard bench for round_target_gen: the driver predicts each round's outcome,
// a negedge monitor checks every result pulse against the queued prediction.
module tb_round_target_gen;
  localparam int TO = 8;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic rst, start, submit, match;
  logic [3:0] target, round_no, score;
  logic target_valid, result_ok, result_miss, game_over;

  round_target_gen #(.TIMEOUT_CYCLES(TO), .MAX_ROUNDS(MR), .LFSR_SEED(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_submit(submit), .i_match(match),
    .o_target(target), .o_target_valid(target_valid), .o_round_no(round_no),
    .o_score(score), .o_result_ok(result_ok), .o_result_miss(result_miss),
    .o_game_over(game_over));

  always #5 clk = ~clk;

  typedef struct {bit ok; int score; int round;} exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int exp_score, exp_round, prev_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (result_ok || result_miss) begin
      chk("pulse_exclusive", int'(result_ok & result_miss), 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("result_ok", int'(result_ok), int'(e.ok));
        chk("result_miss", int'(result_miss), int'(!e.ok));
        chk("score_at_result", int'(score), e.score);
        chk("round_at_result", int'(round_no), e.round);
        chk("valid_low_at_result", int'(target_valid), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = 0;
    exp_round = 0;
  endtask

  // Waits for the round to open; returns edges waited (40 means it never opened)
  task automatic wait_valid(output int n);
    n = 0;
    while (!target_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // timeout=1: no submit; otherwise submit in SHOW cycle d (1..TO) with match=hit
  task automatic play_round(input bit timeout, input int d, input bit hit);
    int n;
    exp_t e;
    wait_valid(n);
    if (n >= 40) begin
      chk("gen_lockup", n, 0);
      return;
    end
    exp_round++;
    chk("round_no_open", int'(round_no), exp_round);
    if (exp_round > 1) chk("no_repeat", int'(target != prev_t[3:0]), 1);
    prev_t = int'(target);
    if (timeout) begin
      repeat (TO - 1) tick();
      chk("no_early_miss", int'(result_miss), 0);
      chk("valid_before_expiry", int'(target_valid), 1);
      e.ok = 1'b0; e.score = exp_score; e.round = exp_round;
      q.push_back(e);
      tick();
      chk("timeout_miss", int'(result_miss), 1);
    end else begin
      repeat (d - 1) tick();
      submit = 1'b1;
      match  = hit;
      if (hit) exp_score = (exp_score >= 15) ? 15 : exp_score + 1;
      e.ok = hit; e.score = exp_score; e.round = exp_round;
      q.push_back(e);
      tick();
      submit = 1'b0;
      match  = 1'b0;
    end
    if (exp_round == MR) begin
      tick();
      chk("game_over", int'(game_over), 1);
      chk("final_score", int'(score), exp_score);
      chk("final_round", int'(round_no), MR);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    rst = 1'b1; start = 1'b0; submit = 1'b0; match = 1'b0;
    exp_score = 0; exp_round = 0; prev_t = 0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_target", int'(target), 0);
    chk("idle_valid", int'(target_valid), 0);
    chk("idle_round", int'(round_no), 0);
    chk("idle_score", int'(score), 0);
    chk("idle_ok", int'(result_ok), 0);
    chk("idle_miss", int'(result_miss), 0);
    chk("idle_over", int'(game_over), 0);

    // first game: hit, timeout miss, hit on the final SHOW cycle
    do_start();
    wait_valid(n);
    chk("first_latency_ok", int'(n >= 1 && n <= 7), 1);
    exp_round = 1;
    chk("first_round_no", int'(round_no), 1);
    prev_t = int'(target);
    repeat (2) tick();
    submit = 1'b1; match = 1'b1;
    exp_score = 1;
    q.push_back('{ok: 1'b1, score: 1, round: 1});
    tick();
    submit = 1'b0; match = 1'b0;
    chk("hit_score", int'(score), 1);
    play_round(1'b1, 0, 1'b0);
    play_round(1'b0, TO, 1'b1);
    chk("game1_score", int'(score), 2);
    repeat (4) tick();
    chk("done_holds_over", int'(game_over), 1);
    chk("done_valid_low", int'(target_valid), 0);
    chk("done_round_holds", int'(round_no), 3);

    // restart from DONE, then reset in the middle of SHOW
    do_start();
    chk("restart_score", int'(score), 0);
    chk("restart_round", int'(round_no), 0);
    chk("restart_over", int'(game_over), 0);
    wait_valid(n);
    chk("restart_open", int'(n < 40), 1);
    chk("restart_round1", int'(round_no), 1);
    tick();
    do_start();
    chk("start_ignored_round", int'(round_no), 1);
    chk("start_ignored_valid", int'(target_valid), 1);
    rst = 1'b1;
    tick();
    chk("rst_target", int'(target), 0);
    chk("rst_valid", int'(target_valid), 0);
    chk("rst_round", int'(round_no), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_over", int'(game_over), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_pulse", int'(result_ok | result_miss), 0);

    // randomized games: varied start timing, submit timing and outcomes
    for (int g = 0; g < 67; g++) begin
      repeat ($urandom_range(0, 5)) tick();
      do_start();
      for (int r = 0; r < MR; r++) begin
        if ($urandom_range(0, 3) == 0) play_round(1'b1, 0, 1'b0);
        else play_round(1'b0, $urandom_range(1, TO), 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
